// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I fetch-stage sequencer. Owns the fetch PC, issues one
// hold-until-resp instruction read at a time, buffers returned words with
// their PCs in a small FIFO and hands them to decode over valid/ready.
// Redirects flush the buffer; a read still in flight at redirect time is
// drained (its data discarded) before the new target is requested.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h6000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic {S_FETCH, S_DRAIN} state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_drain_addr;
    logic [31:0]        r_buf_pc   [BUF_DEPTH];
    logic [31:0]        r_buf_inst [BUF_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_target;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    // Read/valid must drop while rst is high and rise in the very cycle rst
    // is released, so the handshake outputs are decoded from state, not registered.
    always_comb begin
        imem_read    = !rst && ((r_state == S_DRAIN) || (r_count < DEPTH_C));
        imem_address = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
        inst_valid   = !rst && (r_state == S_FETCH) && (r_count != '0);
        inst_out     = r_buf_inst[r_rd_ptr];
        inst_pc      = r_buf_pc[r_rd_ptr];
    end

    // Redirect beats both push and pop; a push needs a live FETCH request.
    always_comb begin
        w_target = {redirect_pc[31:2], 2'b00};
        w_push   = (r_state == S_FETCH) && imem_read && imem_resp && !redirect;
        w_pop    = inst_valid && inst_ready && !redirect;
    end

    // Control state: FSM, fetch PC, drain address, FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else if (redirect) begin
            r_pc     <= w_target;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // A request still open (no resp this cycle) must be drained;
            // in DRAIN imem_address already equals the drain address.
            if (imem_read && !imem_resp) begin
                r_state      <= S_DRAIN;
                r_drain_addr <= imem_address;
            end else begin
                r_state <= S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: if (w_push) r_pc <= r_pc + 32'd4;
                S_DRAIN: if (imem_resp) r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: payload only, validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_buf_pc[r_wr_ptr]   <= r_pc;
            r_buf_inst[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
